// File: rtl/pxl_collector_pkg.sv
// Shared constants for the pixel result collector.
//   - Wishbone register word offsets (wbs_adr_i[3:2])
//   - CTRL / STATUS / DATA bit positions
//   - Layout of one 16-bit FIFO entry: {idx[7:0], kdone, 3'b0, q[3:0]}
package pxl_collector_pkg;

  localparam int ENTRY_W = 16;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_TH_LSB = 3;
  localparam int CTRL_TH_MSB = 8;

  // STATUS bits
  localparam int ST_CNT_MSB = 6;
  localparam int ST_EMPTY   = 7;
  localparam int ST_FULL    = 8;
  localparam int ST_OVF     = 9;

  // DATA bits
  localparam int DATA_VALID = 31;

  // Entry fields
  localparam int IDX_MSB   = 15;
  localparam int IDX_LSB   = 8;
  localparam int KDONE_BIT = 7;
  localparam int Q_MSB     = 3;
  localparam int Q_LSB     = 0;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [7:0] idx,
                                                    input logic       kdone,
                                                    input logic [3:0] q);
    logic [ENTRY_W-1:0] e;
    e                  = '0;
    e[IDX_MSB:IDX_LSB] = idx;
    e[KDONE_BIT]       = kdone;
    e[Q_MSB:Q_LSB]     = q;
    return e;
  endfunction

endpackage

// File: rtl/pxl_result_fifo.sv
// Synchronous FIFO holding captured pixel results.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the FIFO; wins over push/pop in the same cycle
//   push, push_data   write request; accepted when not full or when a pop
//                     happens in the same cycle
//   pop               read request; ignored when empty (a same-cycle push
//                     is still kept)
//   head              entry at the read pointer (meaningful when !empty)
//   count, full, empty occupancy
module pxl_result_fifo #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push at full still fits.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pxl_result_collector.sv
// Pixel result collector: captures each pixel-done event from the pixel FSM
// into a FIFO that firmware drains over Wishbone, with a threshold/overflow
// interrupt.
// Ports:
//   wb_clk_i, wb_rst_ni            clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i     Wishbone slave request
//   wbs_adr_i, wbs_dat_i           address, write data
//   wbs_ack_o, wbs_dat_o           acknowledge, read data
//   pxl_done_i, pxl_q_i            pixel done level and 4-bit result
//   kernel_done_i                  kernel complete flag
//   irq_o                          level interrupt
module pxl_result_collector
  import pxl_collector_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] BASE_NIB    = 4'h3,
  parameter logic [3:0] SUB_NIB     = 4'h1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        pxl_done_i,
  input  logic [3:0]  pxl_q_i,
  input  logic        kernel_done_i,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);

  // Synchronizers and edge detect
  logic [SYNC_STAGES-1:0] done_sync;
  logic [SYNC_STAGES-1:0] kd_sync;
  logic                   done_d;
  logic                   done_s;
  logic                   kd_s;
  logic                   evt;

  // Control / status
  logic       ctrl_en;
  logic       ctrl_irq_en;
  logic [5:0] ctrl_thresh;
  logic       ovf;
  logic [7:0] idx;

  // Capture stage
  logic               cap_valid;
  logic [ENTRY_W-1:0] cap_entry;

  // FIFO
  logic [ENTRY_W-1:0] fifo_head;
  logic [AW:0]        fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [6:0]         count7;

  // Wishbone decode
  logic        adr_match;
  logic        access;
  reg_off_e    reg_sel;
  logic [3:0]  wstrb;
  logic        ctrl_wr_b0;
  logic        ctrl_wr_b1;
  logic        clr_now;
  logic        ovf_w1c;
  logic        pop;
  logic        push;
  logic        drop;
  logic        irq_cond;
  logic [31:0] rdata;

  assign done_s = done_sync[SYNC_STAGES-1];
  assign kd_s   = kd_sync[SYNC_STAGES-1];
  assign evt    = done_s & ~done_d & ctrl_en;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      done_sync <= '0;
      kd_sync   <= '0;
      done_d    <= 1'b0;
    end else begin
      done_sync <= {done_sync[SYNC_STAGES-2:0], pxl_done_i};
      kd_sync   <= {kd_sync[SYNC_STAGES-2:0], kernel_done_i};
      done_d    <= done_s;
    end
  end

  // Handshake: a request is accepted in a cycle where cyc & stb are high,
  // the address matches and no ack is currently being returned. The ack
  // follows one cycle later for exactly one cycle, carrying the read data;
  // all side effects (pop, register write) land on that same clock edge.
  assign adr_match  = (wbs_adr_i[31:28] == BASE_NIB) && (wbs_adr_i[11:8] == SUB_NIB);
  assign access     = wbs_cyc_i & wbs_stb_i & adr_match & ~wbs_ack_o;
  assign reg_sel    = reg_off_e'(wbs_adr_i[3:2]);
  assign wstrb      = wbs_sel_i & {4{wbs_we_i}};
  assign ctrl_wr_b0 = access & (reg_sel == REG_CTRL) & wstrb[0];
  assign ctrl_wr_b1 = access & (reg_sel == REG_CTRL) & wstrb[1];
  assign clr_now    = ctrl_wr_b0 & wbs_dat_i[CTRL_CLR];
  assign ovf_w1c    = access & (reg_sel == REG_STATUS) & wstrb[1] & wbs_dat_i[ST_OVF];
  assign pop        = access & ~wbs_we_i & (reg_sel == REG_DATA);

  // A captured entry pushes one cycle after the edge. If the FIFO is full
  // and no pop frees a slot, it is dropped and flagged.
  assign push = cap_valid & ~clr_now;
  assign drop = push & fifo_full & ~pop;

  pxl_result_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .flush     (clr_now),
    .push      (push),
    .push_data (cap_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign count7   = 7'(fifo_count);
  assign irq_cond = ctrl_irq_en &
                    (((ctrl_thresh != 6'd0) && (count7 >= {1'b0, ctrl_thresh})) | ovf);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cap_valid <= 1'b0;
      cap_entry <= '0;
      idx       <= 8'd0;
    end else if (clr_now) begin
      cap_valid <= 1'b0;
      idx       <= 8'd0;
    end else begin
      cap_valid <= evt;
      if (evt) begin
        cap_entry <= make_entry(idx, kd_s, pxl_q_i);
        idx       <= idx + 8'd1;  // counts dropped events too
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_thresh <= 6'd0;
      ovf         <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (ctrl_wr_b0) begin
        ctrl_en          <= wbs_dat_i[CTRL_EN];
        ctrl_irq_en      <= wbs_dat_i[CTRL_IRQ_EN];
        ctrl_thresh[4:0] <= wbs_dat_i[7:CTRL_TH_LSB];
      end
      if (ctrl_wr_b1) ctrl_thresh[5] <= wbs_dat_i[CTRL_TH_MSB];
      // A fresh overflow wins over a same-cycle W1C so it is never lost.
      if (clr_now)      ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_w1c) ovf <= 1'b0;
      irq_o <= irq_cond;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]                 = ctrl_en;
        rdata[CTRL_IRQ_EN]             = ctrl_irq_en;
        rdata[CTRL_TH_MSB:CTRL_TH_LSB] = ctrl_thresh;
      end
      REG_STATUS: begin
        rdata[ST_CNT_MSB:0] = count7;
        rdata[ST_EMPTY]     = fifo_empty;
        rdata[ST_FULL]      = fifo_full;
        rdata[ST_OVF]       = ovf;
      end
      REG_DATA: begin
        if (!fifo_empty) begin
          rdata[DATA_VALID]     = 1'b1;
          rdata[ENTRY_W-1:0]    = fifo_head;
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : 32'd0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[27:12], wbs_adr_i[7:4], wbs_adr_i[1:0],
                         wbs_dat_i[31:10], wstrb[3:2]};

endmodule

// File: tb/tb_pxl_result_collector.sv
module tb_pxl_result_collector;

  localparam logic [31:0] A_CTRL   = 32'h3000_0100;
  localparam logic [31:0] A_STATUS = 32'h3000_0104;
  localparam logic [31:0] A_DATA   = 32'h3000_0108;
  localparam logic [31:0] A_RSVD   = 32'h3000_010C;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wbs_stb = 0, wbs_cyc = 0, wbs_we = 0;
  logic [3:0]  wbs_sel = 0;
  logic [31:0] wbs_adr = 0, wbs_dat = 0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        pxl_done = 0, kernel_done = 0;
  logic [3:0]  pxl_q = 0;
  logic        irq_o;

  pxl_result_collector dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .wbs_stb_i     (wbs_stb),
    .wbs_cyc_i     (wbs_cyc),
    .wbs_we_i      (wbs_we),
    .wbs_sel_i     (wbs_sel),
    .wbs_adr_i     (wbs_adr),
    .wbs_dat_i     (wbs_dat),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .pxl_done_i    (pxl_done),
    .pxl_q_i       (pxl_q),
    .kernel_done_i (kernel_done),
    .irq_o         (irq_o)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        cur_we = 1'b0;
  string       cur_name = "";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // monitor: every ack consumes one expected entry; reads are compared
  always @(negedge clk) begin
    if (wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_ack");
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (!cur_we) check(cur_name, wbs_dat_o, e);
      end
    end
  end

  // driver tasks
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp, input string name);
    bit got;
    cur_we   = we;
    cur_name = name;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = we; wbs_adr = adr; wbs_dat = dat; wbs_sel = sel;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o === 1'b1) got = 1;
    end
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    if (!got) begin
      fail_now({"ack_timeout_", name});
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
    wb_cycle(1'b0, adr, 32'd0, 4'hF, exp, name);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_cycle(1'b1, adr, dat, sel, 32'd0, "write");
  endtask

  task automatic wb_noack(input logic [31:0] adr, input string name);
    bit seen;
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = adr; wbs_sel = 4'hF;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wbs_ack_o !== 1'b0) seen = 1;
    end
    wbs_cyc = 0; wbs_stb = 0;
    check(name, {31'd0, seen}, 32'd0);
  endtask

  // pixel done pulse: high 4 cycles, low 4 cycles
  task automatic pulse(input logic [3:0] q, input logic kd);
    @(posedge clk); #1;
    pxl_done = 1; pxl_q = q; kernel_done = kd;
    repeat (4) @(posedge clk);
    #1;
    pxl_done = 0; kernel_done = 0;
    repeat (4) @(posedge clk);
  endtask

  // read access cycle lines up with the push cycle of the pulse's entry
  task automatic pulse_and_read(input logic [3:0] q, input logic [31:0] exp, input string name);
    fork
      pulse(q, 1'b0);
      begin
        repeat (3) @(posedge clk);
        wb_read(A_DATA, exp, name);
      end
    join
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    wb_read(A_STATUS, 32'h0000_0080, "status_after_reset");

    // basic capture
    wb_write(A_CTRL, 32'h1, 4'hF);
    pulse(4'h5, 0); pulse(4'hA, 0); pulse(4'h3, 0);
    wb_read(A_STATUS, 32'h0000_0003, "status_count3");
    wb_read(A_DATA, 32'h8000_0005, "data0");
    wb_read(A_DATA, 32'h8000_010A, "data1");
    wb_read(A_DATA, 32'h8000_0203, "data2");
    wb_read(A_DATA, 32'h0000_0000, "data_empty");
    wb_read(A_STATUS, 32'h0000_0080, "status_empty");

    // overflow and index wrap-through
    wb_write(A_CTRL, 32'h3, 4'hF);
    for (int i = 0; i < 18; i++) pulse(4'(i), 0);
    wb_read(A_STATUS, 32'h0000_0310, "status_full_ovf");
    wb_read(A_DATA, 32'h8000_0000, "ovf_first");
    pulse(4'h2, 0);
    for (int i = 1; i < 16; i++) wb_read(A_DATA, 32'h8000_0000 | (i << 8) | i, "ovf_drain");
    wb_read(A_DATA, 32'h8000_1202, "ovf_idx18");
    wb_read(A_STATUS, 32'h0000_0280, "status_ovf_sticky");
    wb_write(A_STATUS, 32'h200, 4'b0001);
    wb_read(A_STATUS, 32'h0000_0280, "ovf_w1c_wrong_byte");
    wb_write(A_STATUS, 32'h200, 4'b0010);
    wb_read(A_STATUS, 32'h0000_0080, "ovf_w1c");

    // threshold interrupt
    wb_write(A_CTRL, 32'h27, 4'hF);
    check("irq_idle", {31'd0, irq_o}, 32'd0);
    pulse(4'h1, 0); pulse(4'h2, 0); pulse(4'h3, 0);
    check("irq_below_thresh", {31'd0, irq_o}, 32'd0);
    pulse(4'h4, 0);
    check("irq_at_thresh", {31'd0, irq_o}, 32'd1);
    wb_read(A_DATA, 32'h8000_0001, "irq_pop");
    check("irq_ack_cycle", {31'd0, irq_o}, 32'd1);
    @(posedge clk); #1;
    check("irq_fall", {31'd0, irq_o}, 32'd0);

    // same-cycle push and pop at full and at empty
    wb_write(A_CTRL, 32'h3, 4'hF);
    for (int i = 0; i < 16; i++) pulse(4'(i), 0);
    wb_read(A_STATUS, 32'h0000_0110, "status_full");
    pulse_and_read(4'hC, 32'h8000_0000, "pushpop_full");
    wb_read(A_STATUS, 32'h0000_0110, "pushpop_full_status");
    wb_write(A_CTRL, 32'h3, 4'hF);
    wb_read(A_STATUS, 32'h0000_0080, "clr_status");
    pulse_and_read(4'h7, 32'h0000_0000, "pushpop_empty");
    wb_read(A_STATUS, 32'h0000_0001, "pushpop_empty_status");
    wb_read(A_DATA, 32'h8000_0007, "pushpop_empty_kept");

    // kernel done flag and clr
    pulse(4'hF, 1);
    wb_read(A_DATA, 32'h8000_018F, "kdone_entry");
    pulse(4'h6, 0);
    wb_read(A_STATUS, 32'h0000_0001, "pre_clr_status");
    wb_write(A_CTRL, 32'h3, 4'hF);
    wb_read(A_STATUS, 32'h0000_0080, "post_clr_status");
    wb_read(A_CTRL, 32'h0000_0001, "ctrl_en_kept");
    pulse(4'h9, 0);
    wb_read(A_DATA, 32'h8000_0009, "idx_restart");

    // byte strobes, reserved word, address decode
    wb_write(A_CTRL, 32'hFFFF_FFFF, 4'b0010);
    wb_read(A_CTRL, 32'h0000_0101, "ctrl_byte1_only");
    wb_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_RSVD, 32'h0000_0000, "rsvd_read");
    wb_noack(32'h3000_0208, "noack_sub");
    wb_noack(32'h2000_0108, "noack_base");

    // reset during a read with entries pending
    wb_write(A_CTRL, 32'h27, 4'hF);
    for (int i = 0; i < 5; i++) pulse(4'(i), 0);
    check("irq_before_rst", {31'd0, irq_o}, 32'd1);
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = A_DATA; wbs_sel = 4'hF;
    #3;
    rst_n = 0;
    #1;
    check("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("midrst_dat", wbs_dat_o, 32'd0);
    check("midrst_irq", {31'd0, irq_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_ack_held", {31'd0, wbs_ack_o}, 32'd0);
    wbs_cyc = 0; wbs_stb = 0;
    @(posedge clk); #1;
    rst_n = 1;
    wb_read(A_STATUS, 32'h0000_0080, "status_after_midrst");
    wb_read(A_CTRL, 32'h0000_0000, "ctrl_after_midrst");

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pxl_result_collector.md
Name: pxl_result_collector

Overview:
- Downstream consumer of the pixel FSM macro. Detects each pixel-done event and captures the 4-bit pixel result with a kernel-done flag and a running sample index. Buffers entries in a small FIFO that firmware drains over Wishbone.
- Raises an interrupt on a programmable fill threshold or on overflow, so the RISC-V core does not have to poll the logic analyzer.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- SYNC_STAGES, 2, synchronizer flops on pxl_done_i and kernel_done_i; pixel clock may be muxed from an external source.
- BASE_NIB, 4'h3, required value of wbs_adr_i[31:28].
- SUB_NIB, 4'h1, required value of wbs_adr_i[11:8]; keeps this block clear of the pixel control register window.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  WB strobe
- wbs_cyc_i  in  1  WB cycle
- wbs_we_i  in  1  WB write enable
- wbs_sel_i  in  4  WB byte selects
- wbs_adr_i  in  32  WB address
- wbs_dat_i  in  32  WB write data
- wbs_ack_o  out  1  WB acknowledge
- wbs_dat_o  out  32  WB read data
- pxl_done_i  in  1  pixel FSM done (level; result valid while high)
- pxl_q_i  in  4  pixel result; stable while pxl_done_i is high
- kernel_done_i  in  1  kernel-complete flag from the pixel FSM
- irq_o  out  1  interrupt, level

Behaviour:
- Reset (async, wb_rst_ni=0):
  - FIFO empty; all registers 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - Sample index 0. Synchronizer flops and edge-detect history 0.
- Capture:
  - pxl_done_i and kernel_done_i each pass through SYNC_STAGES flops.
  - Event = synchronized done 0->1, gated by CTRL.en.
  - On an event, pxl_q_i is registered in the same cycle the sync edge is seen. Entry {idx[7:0], kdone, 3'b0, q[3:0]} is pushed the following cycle.
  - idx increments mod 256 on every event, including dropped ones.
  - kdone is the synchronized kernel_done_i level at the event.
- Full: event is dropped and STATUS.ovf sets (sticky).
- Registers, byte offset = wbs_adr_i[3:2]*4:
  - 0x0 CTRL (R/W): [0] en, [1] clr (self-clearing), [2] irq_en, [8:3] thresh (0..DEPTH).
  - 0x4 STATUS: [6:0] count, [7] empty, [8] full, [9] ovf. Writing 1 to bit 9 clears ovf; all other bits read-only.
  - 0x8 DATA (RO): [31] valid, [15:0] head entry. A read pops one entry when not empty. A read when empty returns 0 and has no side effect.
  - 0xC: reads 0, writes ignored.
- Writes apply only to bytes whose wstrb bit is set (wstrb = wbs_sel_i & we).
- Wishbone access:
  - Access = cyc & stb & BASE_NIB/SUB_NIB match & !wbs_ack_o.
  - wbs_ack_o pulses exactly one cycle, one cycle after the access is detected; wbs_dat_o is valid with the ack.
  - Non-matching addresses get no ack.
  - Back-to-back accesses are ack'd every other cycle.
  - The pop takes effect on the ack cycle; data presented is the pre-pop head.
- Simultaneous push and pop: both occur and count is unchanged.
  - Push when full with a pop in the same cycle: accepted, no overflow.
  - Pop on empty with a push in the same cycle: the read returns empty (valid=0); the push is kept.
- clr: flushes the FIFO and clears ovf and idx in one cycle. It takes priority over a same-cycle push; en is retained.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.
- irq_o (registered) = irq_en & ((thresh!=0 & count>=thresh) | ovf). Deasserts the cycle after the condition clears.
- Reset mid-operation: all state is lost immediately. No partial entry survives. An in-flight WB cycle gets no ack.

Decomposition:
- Package pxl_collector_pkg holds:
  - register offsets (CTRL/STATUS/DATA);
  - CTRL/STATUS bit positions;
  - entry field positions (IDX_MSB/LSB, KDONE_BIT, Q_MSB/LSB);
  - ENTRY_W=16.
- One sub-module, pxl_result_fifo: synchronous FIFO with DEPTH/ENTRY_W parameters, push/pop/flush inputs, head/count/full/empty outputs, same-cycle push+pop at full/empty as specified above.
- Synchronizer, edge detect, register file and WB logic stay in the top module.

Test Plan:
- Reset then en=1. Three done pulses with q=5,A,3 -> STATUS count=3. DATA reads return 0x80000005, 0x8000010A, 0x80000203, then 0x00000000 (empty, valid=0).
- DEPTH=16, 18 events with no reads -> full=1, ovf=1, count=16. First read idx=0, last read idx=15. Next event after one pop gets idx=18 (0x12).
- thresh=4, irq_en=1. Four events -> irq_o rises within 1 cycle of count reaching 4. One DATA read -> irq_o falls the cycle after count=3.
- Push and pop in the same cycle at count=16 and at count=0 -> count is 16 and 1 respectively; ovf stays 0.
- kernel_done_i high during an event with q=F -> entry bit 7 set (0x80000??8F form). Write CTRL.clr -> count=0, idx restarts at 0, ovf=0, en still 1.
- Assert wb_rst_ni low mid-WB-read with count=5 -> no ack, irq_o=0, all outputs 0 immediately. After release STATUS reads 0x80 (empty).
